// File: rtl/memory_access_stage.sv
// RV32I memory stage: data RAM with byte-enabled stores, sized loads,
// MEM/WB register and writeback result mux.
module memory_access_stage #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult_M,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PC_Plus4M,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  output logic [31:0] ALUResult_W,
  output logic [31:0] ReadDataW,
  output logic [31:0] PC_Plus4W,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ResultW,
  output logic        MisalignW
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   ram [MEM_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    off;

  assign idx = ALUResult_M[AW+1:2];
  assign off = ALUResult_M[1:0];

  logic is_load;
  logic is_store;
  logic active;
  logic sz_b;
  logic sz_h;
  logic sz_w;
  logic uns;
  logic bad_f3;
  logic illegal;
  logic misal;
  logic bad;

  always_comb begin
    sz_b   = 1'b0;
    sz_h   = 1'b0;
    sz_w   = 1'b0;
    uns    = 1'b0;
    bad_f3 = 1'b0;
    case (funct3M)
      3'b000: sz_b = 1'b1;
      3'b001: sz_h = 1'b1;
      3'b010: sz_w = 1'b1;
      3'b100: begin
        sz_b = 1'b1;
        uns  = 1'b1;
      end
      3'b101: begin
        sz_h = 1'b1;
        uns  = 1'b1;
      end
      default: bad_f3 = 1'b1;
    endcase
  end

  always_comb begin
    is_load  = (ResultSrcM == 2'b01);
    is_store = MemWriteM;
    active   = is_load | is_store;
    illegal  = bad_f3 | (is_store & uns);
    misal    = (sz_h & off[0]) | (sz_w & (off != 2'b00));
    bad      = active & (illegal | misal);
  end

  logic [3:0]  be;
  logic [31:0] wdata;

  // Bad stores and stores during reset never reach the RAM.
  always_comb begin
    be    = 4'b0000;
    wdata = WriteDataM;
    if (sz_b)
      wdata = {4{WriteDataM[7:0]}};
    else if (sz_h)
      wdata = {2{WriteDataM[15:0]}};
    if (is_store && !bad && !reset) begin
      if (sz_b)
        be = 4'b0001 << off;
      else if (sz_h)
        be = off[1] ? 4'b1100 : 4'b0011;
      else if (sz_w)
        be = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i])
        ram[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  logic [31:0] rword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ld;

  always_comb begin
    rword = ram[idx];
    rbyte = rword[{off, 3'b000} +: 8];
    rhalf = off[1] ? rword[31:16] : rword[15:0];
    ld    = 32'h0;
    if (!bad) begin
      if (sz_b)
        ld = uns ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      else if (sz_h)
        ld = uns ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      else if (sz_w)
        ld = rword;
    end
  end

  logic [31:0] alu_d, alu_q;
  logic [31:0] rd_data_d, rd_data_q;
  logic [31:0] pc4_d, pc4_q;
  logic [4:0]  rd_d, rd_q;
  logic        rw_d, rw_q;
  logic [1:0]  rsrc_d, rsrc_q;
  logic        mis_d, mis_q;

  always_comb begin
    alu_d     = ALUResult_M;
    rd_data_d = ld;
    pc4_d     = PC_Plus4M;
    rd_d      = RdM;
    rsrc_d    = ResultSrcM;
    mis_d     = bad;
    rw_d      = RegWriteM & ~bad & (RdM != 5'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_q     <= 32'h0;
      rd_data_q <= 32'h0;
      pc4_q     <= 32'h0;
      rd_q      <= 5'd0;
      rw_q      <= 1'b0;
      rsrc_q    <= 2'b00;
      mis_q     <= 1'b0;
    end else begin
      alu_q     <= alu_d;
      rd_data_q <= rd_data_d;
      pc4_q     <= pc4_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      rsrc_q    <= rsrc_d;
      mis_q     <= mis_d;
    end
  end

  assign ALUResult_W = alu_q;
  assign ReadDataW   = rd_data_q;
  assign PC_Plus4W   = pc4_q;
  assign RdW         = rd_q;
  assign RegWriteW   = rw_q;
  assign ResultSrcW  = rsrc_q;
  assign MisalignW   = mis_q;

  always_comb begin
    ResultW = 32'h0;
    case (rsrc_q)
      2'b00:   ResultW = alu_q;
      2'b01:   ResultW = rd_data_q;
      2'b10:   ResultW = pc4_q;
      default: ResultW = 32'h0;
    endcase
  end

endmodule
